div_seq: RTL and testbench

Parametrised sequential integer divider for the eJ32 ALU, serving `idiv`/`irem` and their unsigned variants. It retires `BPC` quotient bits per clock with restoring division and supports Java signed semantics, with a truncate-toward-zero quotient and a remainder that takes the dividend's sign. It has an explicit start/busy/done handshake and flags divide-by-zero and overflow. It sits beside the shifter and multiplier as an external ALU unit, driven by the core's execute stage.

---
 rtl/div_seq_if.sv | 26 ++
 rtl/div_seq.sv | 198 +++++++++++++++++++
 tb/tb_div_seq.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_seq_if.sv
// Start/busy/done handshake and operand/result bus of the sequential divider.
// The driver uses the master modport and the divider uses the slave modport.
interface div_seq_if #(
  parameter int unsigned DSZ = 32
);
  logic           start;
  logic           sgn;
  logic [DSZ-1:0] x;
  logic [DSZ-1:0] y;
  logic           busy;
  logic           done;
  logic           z;
  logic           ovf;
  logic [DSZ-1:0] q;
  logic [DSZ-1:0] r;

  modport master (
    output start, sgn, x, y,
    input  busy, done, z, ovf, q, r
  );

  modport slave (
    input  start, sgn, x, y,
    output busy, done, z, ovf, q, r
  );
endinterface

// File: rtl/div_seq.sv
// Sequential restoring divider retiring BPC quotient bits per cycle (IDLE -> RUN -> FIX).
// Java signed semantics are compiled in only when DIV_SIGNED_EN is defined.
module div_seq #(
  parameter int unsigned DSZ = 32,
  parameter int unsigned BPC = 1
) (
  input logic       clk,
  input logic       rst,
  div_seq_if.slave  bus
);

  localparam int unsigned N    = DSZ / BPC;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e         state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [DSZ:0]   rem_q, rem_d;
  logic [DSZ-1:0] dvd_q, dvd_d;
  logic [DSZ-1:0] dvs_q, dvs_d;
  logic           zp_q, zp_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           z_q, z_d;
  logic [DSZ-1:0] q_q, q_d;
  logic [DSZ-1:0] r_q, r_d;

  logic [DSZ-1:0] mag_x, mag_y;
  logic [DSZ-1:0] q_fix, r_fix;
  logic [DSZ:0]   step_rem;
  logic [DSZ-1:0] step_dvd;

`ifdef DIV_SIGNED_EN
  logic qneg_q, qneg_d;
  logic rneg_q, rneg_d;
  logic ovfp_q, ovfp_d;
  logic ovf_q, ovf_d;
  logic sx, sy, ovf_det;

  always_comb begin
    sx      = bus.sgn & bus.x[DSZ-1];
    sy      = bus.sgn & bus.y[DSZ-1];
    mag_x   = sx ? -bus.x : bus.x;
    mag_y   = sy ? -bus.y : bus.y;
    ovf_det = bus.sgn & (bus.x == {1'b1, {(DSZ-1){1'b0}}}) & (&bus.y);
    q_fix   = qneg_q ? -dvd_q : dvd_q;
    r_fix   = rneg_q ? -rem_q[DSZ-1:0] : rem_q[DSZ-1:0];
  end

  assign bus.ovf = ovf_q;
`else
  logic unused_sgn;
  assign unused_sgn = bus.sgn;

  always_comb begin
    mag_x = bus.x;
    mag_y = bus.y;
    q_fix = dvd_q;
    r_fix = rem_q[DSZ-1:0];
  end

  assign bus.ovf = 1'b0;
`endif

  // BPC chained restoring steps; the dividend register fills with quotient bits from the right.
  always_comb begin
    step_rem = rem_q;
    step_dvd = dvd_q;
    for (int i = 0; i < int'(BPC); i++) begin
      step_rem = {step_rem[DSZ-1:0], step_dvd[DSZ-1]};
      step_dvd = {step_dvd[DSZ-2:0], 1'b0};
      if (step_rem >= {1'b0, dvs_q}) begin
        step_rem    = step_rem - {1'b0, dvs_q};
        step_dvd[0] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    zp_d    = zp_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    z_d     = z_q;
    q_d     = q_q;
    r_d     = r_q;
`ifdef DIV_SIGNED_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    ovfp_d  = ovfp_q;
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          busy_d = 1'b1;
          if (bus.y == '0) begin
            // Zero divisor skips RUN; FIX then emits q=0, r=x through the normal path.
            state_d = StFix;
            zp_d    = 1'b1;
            dvd_d   = '0;
            rem_d   = {1'b0, bus.x};
`ifdef DIV_SIGNED_EN
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
            ovfp_d  = 1'b0;
`endif
          end else begin
            state_d = StRun;
            zp_d    = 1'b0;
            cnt_d   = CntW'(N - 1);
            rem_d   = '0;
            dvd_d   = mag_x;
            dvs_d   = mag_y;
`ifdef DIV_SIGNED_EN
            qneg_d  = sx ^ sy;
            rneg_d  = sx;
            ovfp_d  = ovf_det;
`endif
          end
        end
      end
      StRun: begin
        rem_d = step_rem;
        dvd_d = step_dvd;
        if (cnt_q == '0) begin
          state_d = StFix;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StFix: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        z_d     = zp_q;
        q_d     = q_fix;
        r_d     = r_fix;
`ifdef DIV_SIGNED_EN
        ovf_d   = ovfp_q;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      zp_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      z_q     <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
`ifdef DIV_SIGNED_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      ovfp_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      zp_q    <= zp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      z_q     <= z_d;
      q_q     <= q_d;
      r_q     <= r_d;
`ifdef DIV_SIGNED_EN
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      ovfp_q  <= ovfp_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.z    = z_q;
  assign bus.q    = q_q;
  assign bus.r    = r_q;

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: BPC=1 and BPC=4 instances, expected results from a behavioural model.
// Signed expectations follow DIV_SIGNED_EN exactly as the design does.
module tb_div_seq;

  localparam int unsigned N1 = 32;
  localparam int unsigned N4 = 8;
`ifdef DIV_SIGNED_EN
  localparam bit SignedEn = 1'b1;
`else
  localparam bit SignedEn = 1'b0;
`endif

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
    logic        ovf;
    int          start_cyc;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb1[$];
  exp_t sb4[$];
  logic busy1_prev = 1'b0;
  logic busy4_prev = 1'b0;

  div_seq_if #(.DSZ(32)) bus1 ();
  div_seq_if #(.DSZ(32)) bus4 ();

  div_seq #(.DSZ(32), .BPC(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  div_seq #(.DSZ(32), .BPC(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                 input int n);
    exp_t   e;
    longint sa;
    longint sb;
    e.z = 1'b0;
    e.ovf = 1'b0;
    e.lat = n + 2;
    e.start_cyc = 0;
    if (b == 32'd0) begin
      e.z = 1'b1;
      e.q = 32'd0;
      e.r = a;
      e.lat = 2;
    end else if (s && SignedEn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      e.q = 32'(sa / sb);
      e.r = 32'(sa % sb);
      e.ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  task automatic score(input string pfx, input exp_t e, input logic [31:0] q,
                       input logic [31:0] r, input logic z, input logic ovf,
                       input logic bp, input logic b);
    check({pfx, "_q"}, q, e.q);
    check({pfx, "_r"}, r, e.r);
    check({pfx, "_z"}, 32'(z), 32'(e.z));
    check({pfx, "_ovf"}, 32'(ovf), 32'(e.ovf));
    check({pfx, "_latency"}, 32'(cyc - e.start_cyc), 32'(e.lat));
    check({pfx, "_busy_before_done"}, 32'(bp), 32'd1);
    check({pfx, "_busy_at_done"}, 32'(b), 32'd0);
  endtask

  always @(negedge clk) begin
    if (bus1.done) begin
      if (sb1.size() == 0) check("dut1_unexpected_done", 32'(bus1.done), 32'd0);
      else score("dut1", sb1.pop_front(), bus1.q, bus1.r, bus1.z, bus1.ovf, busy1_prev,
                 bus1.busy);
    end
    busy1_prev = bus1.busy;
  end

  always @(negedge clk) begin
    if (bus4.done) begin
      if (sb4.size() == 0) check("dut4_unexpected_done", 32'(bus4.done), 32'd0);
      else score("dut4", sb4.pop_front(), bus4.q, bus4.r, bus4.z, bus4.ovf, busy4_prev,
                 bus4.busy);
    end
    busy4_prev = bus4.busy;
  end

  // Drives start for one edge from the current time, then scrambles the don't-care inputs.
  task automatic issue1(input logic s, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    bus1.start = 1'b1;
    bus1.sgn = s;
    bus1.x = a;
    bus1.y = b;
    e = model(s, a, b, int'(N1));
    e.start_cyc = cyc;
    sb1.push_back(e);
    @(posedge clk);
    #1;
    bus1.start = 1'b0;
    bus1.sgn = 1'($urandom_range(0, 1));
    bus1.x = $urandom;
    bus1.y = $urandom;
  endtask

  task automatic issue4(input logic s, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    bus4.start = 1'b1;
    bus4.sgn = s;
    bus4.x = a;
    bus4.y = b;
    e = model(s, a, b, int'(N4));
    e.start_cyc = cyc;
    sb4.push_back(e);
    @(posedge clk);
    #1;
    bus4.start = 1'b0;
    bus4.sgn = 1'($urandom_range(0, 1));
    bus4.x = $urandom;
    bus4.y = $urandom;
  endtask

  task automatic wait_done1();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus1.done) break;
    end
    check("dut1_done_seen", 32'(bus1.done), 32'd1);
  endtask

  task automatic wait_done4();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus4.done) break;
    end
    check("dut4_done_seen", 32'(bus4.done), 32'd1);
  endtask

  task automatic check_cleared(input string pfx, input logic busy, input logic done,
                               input logic z, input logic ovf, input logic [31:0] q,
                               input logic [31:0] r);
    check({pfx, "_busy"}, 32'(busy), 32'd0);
    check({pfx, "_done"}, 32'(done), 32'd0);
    check({pfx, "_z"}, 32'(z), 32'd0);
    check({pfx, "_ovf"}, 32'(ovf), 32'd0);
    check({pfx, "_q"}, q, 32'd0);
    check({pfx, "_r"}, r, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    bus1.start = 1'b0; bus1.sgn = 1'b0; bus1.x = '0; bus1.y = '0;
    bus4.start = 1'b0; bus4.sgn = 1'b0; bus4.x = '0; bus4.y = '0;
    // Reset must dominate a pending start.
    bus1.start = 1'b1; bus1.y = 32'd3;
    repeat (3) @(posedge clk);
    #1;
    bus1.start = 1'b0;
    check_cleared("rst1", bus1.busy, bus1.done, bus1.z, bus1.ovf, bus1.q, bus1.r);
    check_cleared("rst4", bus4.busy, bus4.done, bus4.z, bus4.ovf, bus4.q, bus4.r);
    rst = 1'b1;

    @(posedge clk);
    #1;
    issue1(1'b0, 32'd100, 32'd7);
    // A start pulse while busy must be ignored.
    repeat (4) @(posedge clk);
    #1;
    bus1.start = 1'b1; bus1.x = 32'd9; bus1.y = 32'd3;
    @(posedge clk);
    #1;
    bus1.start = 1'b0;
    wait_done1();
    issue1(1'b1, 32'hFFFF_FFF9, 32'd2);          // back-to-back in the done cycle
    wait_done1();
    issue1(1'b1, 32'd7, 32'hFFFF_FFFE);
    wait_done1();
    issue1(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done1();
    @(posedge clk);
    #1;
    issue1(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done1();
    issue1(1'b1, 32'h0000_1234, 32'd0);
    wait_done1();
    repeat (3) @(negedge clk);
    check("z_hold", 32'(bus1.z), 32'd1);
    check("r_hold", bus1.r, 32'h0000_1234);
    @(posedge clk);
    #1;
    issue1(1'b0, 32'd50, 32'd5);
    wait_done1();

    // Abort mid-run: outputs clear and the aborted operation never completes.
    @(posedge clk);
    #1;
    issue1(1'b0, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_cleared("abort1", bus1.busy, bus1.done, bus1.z, bus1.ovf, bus1.q, bus1.r);
    sb1.delete();
    rst = 1'b1;
    repeat (40) @(negedge clk);

    @(posedge clk);
    #1;
    issue4(1'b0, 32'hFFFF_FFFF, 32'h0000_0010);
    wait_done4();
    issue4(1'b1, 32'hFFFF_FF9C, 32'd7);
    wait_done4();
    issue4(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done4();

    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = (i == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      s = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      issue1(s, a, b);
      wait_done1();
      @(posedge clk);
      #1;
      issue4(s, b, a);
      wait_done4();
    end

    repeat (3) @(negedge clk);
    check("sb1_drained", 32'(sb1.size()), 32'd0);
    check("sb4_drained", 32'(sb4.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
